// File: rtl/score_display_ctrl_pkg.sv
// Shared game definitions: game state encoding, score ceiling, converter
// state encoding and small saturation / state-legalising helpers.
// Used by score_display_ctrl (optional HISCORE_EN build) and bin2bcd_seq.
package score_display_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_OVER = 3'd2,
    ST_WIN  = 3'd3
  } state_t;

  // Largest value the two-digit display can show; also the score counter ceiling.
  localparam logic [6:0] SCORE_MAX = 7'd99;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_DONE  = 2'd2
  } cv_state_t;

  // Clamp a 7-bit value to the displayable range.
  function automatic logic [6:0] sat_score(input logic [6:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

  // Encodings 4..7 behave as IDLE.
  function automatic state_t legal_state(input logic [2:0] s);
    case (s)
      3'd1:    return ST_RUN;
      3'd2:    return ST_OVER;
      3'd3:    return ST_WIN;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) converter, 7-bit binary to two BCD
// digits. A start seen in CV_IDLE captures bin; seven shift cycles later the
// result sits in the upper byte of the shift register and done is high for
// exactly one cycle (CV_DONE). ones/tens are only meaningful while done=1.
module bin2bcd_seq
  import score_display_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  cv_state_t   r_state;
  logic [14:0] r_sh;     // [14:11] tens, [10:7] ones, [6:0] binary being consumed
  logic [2:0]  r_cnt;
  logic [14:0] w_adj;

  // Add-3 correction of each BCD nibble ahead of the shift.
  always_comb begin
    w_adj = r_sh;
    if (r_sh[10:7] >= 4'd5) w_adj[10:7] = r_sh[10:7] + 4'd3;
    if (r_sh[14:11] >= 4'd5) w_adj[14:11] = r_sh[14:11] + 4'd3;
  end

  // Converter FSM: capture, seven correct-and-shift steps, one result cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CV_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CV_IDLE: begin
          if (start) begin
            r_sh    <= {8'd0, bin};
            r_cnt   <= '0;
            r_state <= CV_SHIFT;
          end
        end
        CV_SHIFT: begin
          r_sh <= w_adj << 1;
          if (r_cnt == 3'd6) begin
            r_state <= CV_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        CV_DONE: r_state <= CV_IDLE;
        default: r_state <= CV_IDLE;
      endcase
    end
  end

  assign done = (r_state == CV_DONE);
  assign ones = r_sh[10:7];
  assign tens = r_sh[14:11];

endmodule

// File: rtl/score_display_ctrl.sv
// Score display controller: picks the value to show (score, or the session
// high score in OVER/WIN when built with HISCORE_EN), converts it to BCD via
// bin2bcd_seq, multiplexes the two digits onto one bus and flashes the
// display in OVER/WIN. Without HISCORE_EN the high score reads 0 and OVER/WIN
// show the live score.
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int MUX_DIV   = 1000,
  parameter int FLASH_DIV = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic [6:0] score,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       bcd_valid,
  output logic [3:0] display_out,
  output logic       digit_sel,
  output logic       digit_en,
  output logic [6:0] hi_score
);

  localparam int MUX_W   = (MUX_DIV > 2) ? $clog2(MUX_DIV) : 1;
  localparam int FLASH_W = (FLASH_DIV > 2) ? $clog2(FLASH_DIV) : 1;

  state_t w_state;
  logic   w_end;
  logic [6:0] w_score_sat;
  logic [6:0] w_src;
  logic [6:0] w_src_sat;

  assign w_state     = legal_state(state);
  assign w_end       = (w_state == ST_OVER) || (w_state == ST_WIN);
  assign w_score_sat = sat_score(score);

`ifdef HISCORE_EN
  logic [6:0] r_hi_score;
  state_t     r_prev_state;

  // Raise the high score on the cycle the game enters OVER or WIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi_score   <= '0;
      r_prev_state <= ST_IDLE;
    end else begin
      r_prev_state <= w_state;
      if (w_end && (w_state != r_prev_state) && (w_score_sat > r_hi_score))
        r_hi_score <= w_score_sat;
    end
  end

  assign hi_score = r_hi_score;
  assign w_src    = w_end ? r_hi_score : score;
`else
  assign hi_score = 7'd0;
  assign w_src    = score;
`endif

  assign w_src_sat = sat_score(w_src);

  // Conversion bookkeeping: r_busy mirrors the converter being out of CV_IDLE.
  logic       r_first;
  logic       r_busy;
  logic [6:0] r_cap_src;
  logic [6:0] r_last_src;
  logic [3:0] r_bcd_ones;
  logic [3:0] r_bcd_tens;
  logic       r_bcd_valid;
  logic       w_start;
  logic       w_done;
  logic [3:0] w_ones;
  logic [3:0] w_tens;

  assign w_start = !r_busy && (r_first || (w_src_sat != r_last_src));

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .bin   (w_src_sat),
    .done  (w_done),
    .ones  (w_ones),
    .tens  (w_tens)
  );

  // Launch a conversion when the source moves; publish the digits when it ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first     <= 1'b1;
      r_busy      <= 1'b0;
      r_cap_src   <= '0;
      r_last_src  <= '0;
      r_bcd_ones  <= '0;
      r_bcd_tens  <= '0;
      r_bcd_valid <= 1'b0;
    end else if (w_start) begin
      r_first     <= 1'b0;
      r_busy      <= 1'b1;
      r_cap_src   <= w_src_sat;
      r_bcd_valid <= 1'b0;
    end else if (w_done) begin
      r_busy      <= 1'b0;
      r_bcd_ones  <= w_ones;
      r_bcd_tens  <= w_tens;
      r_bcd_valid <= 1'b1;
      r_last_src  <= r_cap_src;
    end
  end

  logic [MUX_W-1:0] r_mux_cnt;
  logic             r_digit_sel;
  logic [3:0]       r_display;

  // Free-running digit multiplexer; the digit bus lags digit_sel by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mux_cnt   <= '0;
      r_digit_sel <= 1'b0;
      r_display   <= '0;
    end else begin
      if (r_mux_cnt == MUX_W'(MUX_DIV - 1)) begin
        r_mux_cnt   <= '0;
        r_digit_sel <= ~r_digit_sel;
      end else begin
        r_mux_cnt <= r_mux_cnt + 1'b1;
      end
      r_display <= r_digit_sel ? r_bcd_tens : r_bcd_ones;
    end
  end

  logic [FLASH_W-1:0] r_flash_cnt;
  logic               r_flash_off;

  // Flash timer runs only in OVER/WIN and restarts lit on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flash_cnt <= '0;
      r_flash_off <= 1'b0;
    end else if (!w_end) begin
      r_flash_cnt <= '0;
      r_flash_off <= 1'b0;
    end else if (r_flash_cnt == FLASH_W'(FLASH_DIV - 1)) begin
      r_flash_cnt <= '0;
      r_flash_off <= ~r_flash_off;
    end else begin
      r_flash_cnt <= r_flash_cnt + 1'b1;
    end
  end

  assign bcd_ones    = r_bcd_ones;
  assign bcd_tens    = r_bcd_tens;
  assign bcd_valid   = r_bcd_valid;
  assign display_out = r_display;
  assign digit_sel   = r_digit_sel;
  assign digit_en    = r_bcd_valid
                     && !(r_digit_sel && (r_bcd_tens == 4'd0))
                     && !(w_end && r_flash_off);

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with MUX_DIV=4, FLASH_DIV=8.
// Expectations for hi_score and the OVER/WIN display follow HISCORE_EN.
module tb_score_display_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state;
  logic [6:0] score;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic       bcd_valid;
  logic [3:0] display_out;
  logic       digit_sel;
  logic       digit_en;
  logic [6:0] hi_score;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  score_display_ctrl #(
    .MUX_DIV   (4),
    .FLASH_DIV (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .score       (score),
    .bcd_ones    (bcd_ones),
    .bcd_tens    (bcd_tens),
    .bcd_valid   (bcd_valid),
    .display_out (display_out),
    .digit_sel   (digit_sel),
    .digit_en    (digit_en),
    .hi_score    (hi_score)
  );

`ifdef HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  typedef struct {
    logic [2:0] st;
    logic [6:0] sc;
    logic       conv;   // 1 when the saturated source actually changes
    logic [3:0] tens;
    logic [3:0] ones;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev_ds;
    int   run_len;
    int   toggles;
    logic [3:0] exp_t;
    logic [3:0] exp_o;

    vecs[0] = '{st: 3'd1, sc: 7'd47,  conv: 1'b1, tens: 4'd4, ones: 4'd7};
    vecs[1] = '{st: 3'd1, sc: 7'd115, conv: 1'b1, tens: 4'd9, ones: 4'd9};
    vecs[2] = '{st: 3'd1, sc: 7'd100, conv: 1'b0, tens: 4'd9, ones: 4'd9};
    vecs[3] = '{st: 3'd0, sc: 7'd5,   conv: 1'b1, tens: 4'd0, ones: 4'd5};
    vecs[4] = '{st: 3'd1, sc: 7'd10,  conv: 1'b1, tens: 4'd1, ones: 4'd0};
    vecs[5] = '{st: 3'd6, sc: 7'd64,  conv: 1'b1, tens: 4'd6, ones: 4'd4};
    vecs[6] = '{st: 3'd1, sc: 7'd99,  conv: 1'b1, tens: 4'd9, ones: 4'd9};
    vecs[7] = '{st: 3'd0, sc: 7'd0,   conv: 1'b1, tens: 4'd0, ones: 4'd0};

    // Reset values
    reset = 1'b1;
    state = 3'd1;
    score = 7'd0;
    step(2);
    chk("rst_ones", bcd_ones, 0);
    chk("rst_tens", bcd_tens, 0);
    chk("rst_valid", bcd_valid, 0);
    chk("rst_disp", display_out, 0);
    chk("rst_sel", digit_sel, 0);
    chk("rst_en", digit_en, 0);
    chk("rst_hi", hi_score, 0);
    $display("[TB] reset checked");

    // First conversion after release: valid on the 9th edge
    reset = 1'b0;
    step(8);
    chk("init_valid_e8", bcd_valid, 0);
    step(1);
    chk("init_valid_e9", bcd_valid, 1);
    chk("init_tens", bcd_tens, 0);
    chk("init_ones", bcd_ones, 0);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("lead_zero_blank", digit_en, !digit_sel);
    end
    $display("[TB] score 0 converted, leading zero blanking checked");

    // Table of single conversions
    for (int i = 0; i < 8; i++) begin
      state = vecs[i].st;
      score = vecs[i].sc;
      step(8);
      chk("vec_valid_e8", bcd_valid, !vecs[i].conv);
      step(1);
      chk("vec_valid_e9", bcd_valid, 1);
      chk("vec_tens", bcd_tens, vecs[i].tens);
      chk("vec_ones", bcd_ones, vecs[i].ones);
      $display("[TB] vec %0d state=%0d score=%0d -> tens=%0d ones=%0d valid=%0d",
               i, vecs[i].st, vecs[i].sc, bcd_tens, bcd_ones, bcd_valid);
    end

    // Source change on the 3rd shift cycle: 12 completes, then 34
    state = 3'd1;
    score = 7'd12;
    step(3);
    score = 7'd34;
    step(5);
    chk("mid_valid_e8", bcd_valid, 0);
    step(1);
    chk("mid_valid_e9", bcd_valid, 1);
    chk("mid_tens_12", bcd_tens, 1);
    chk("mid_ones_12", bcd_ones, 2);
    step(1);
    chk("mid_valid_e10", bcd_valid, 0);
    chk("mid_hold_tens", bcd_tens, 1);
    chk("mid_hold_ones", bcd_ones, 2);
    step(7);
    chk("mid_valid_e17", bcd_valid, 0);
    chk("mid_hold_ones2", bcd_ones, 2);
    step(1);
    chk("mid_valid_e18", bcd_valid, 1);
    chk("mid_tens_34", bcd_tens, 3);
    chk("mid_ones_34", bcd_ones, 4);
    $display("[TB] mid-shift change 12->34 done: tens=%0d ones=%0d", bcd_tens, bcd_ones);

    // Digit multiplexing on 34
    run_len = 0;
    toggles = 0;
    prev_ds = digit_sel;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("mux_display", display_out, prev_ds ? 32'd3 : 32'd4);
      run_len++;
      if (digit_sel != prev_ds) begin
        if (toggles > 0) chk("mux_period", run_len, 4);
        toggles++;
        run_len = 0;
      end
      prev_ds = digit_sel;
    end
    chk("mux_toggled", toggles >= 4, 1);
    $display("[TB] digit mux checked, %0d toggles", toggles);

    // High score: OVER after 23
    score = 7'd23;
    step(9);
    chk("hs_pre_tens", bcd_tens, 2);
    chk("hs_pre_ones", bcd_ones, 3);
    state = 3'd2;
    step(1);
    chk("hs_over_hi", hi_score, HS ? 32'd23 : 32'd0);
    step(20);
    chk("hs_over_valid", bcd_valid, 1);
    chk("hs_over_tens", bcd_tens, 2);
    chk("hs_over_ones", bcd_ones, 3);
    $display("[TB] OVER: hi=%0d display %0d%0d", hi_score, bcd_tens, bcd_ones);

    // WIN after 9: high score unchanged
    state = 3'd1;
    score = 7'd9;
    step(9);
    chk("hs_run9_ones", bcd_ones, 9);
    state = 3'd3;
    step(1);
    chk("hs_win_hi", hi_score, HS ? 32'd23 : 32'd0);
    step(20);
    exp_t = HS ? 4'd2 : 4'd0;
    exp_o = HS ? 4'd3 : 4'd9;
    chk("hs_win_valid", bcd_valid, 1);
    chk("hs_win_tens", bcd_tens, exp_t);
    chk("hs_win_ones", bcd_ones, exp_o);
    $display("[TB] WIN: hi=%0d display %0d%0d", hi_score, bcd_tens, bcd_ones);

    // Flash: 8 lit, 8 blank, 8 lit after entering OVER with a steady value
    state = 3'd1;
    score = 7'd23;
    step(20);
    chk("fl_pre_valid", bcd_valid, 1);
    chk("fl_pre_tens", bcd_tens, 2);
    state = 3'd2;
    for (int k = 0; k < 24; k++) begin
      chk("flash_phase", digit_en, ((k / 8) % 2) == 0);
      step(1);
    end
    chk("fl_hi", hi_score, HS ? 32'd23 : 32'd0);
    $display("[TB] flash pattern checked");

    // Reset asserted mid-conversion while in OVER
    state = 3'd1;
    score = 7'd77;
    step(3);
    state = 3'd2;
    reset = 1'b1;
    #1;
    chk("ar_ones", bcd_ones, 0);
    chk("ar_tens", bcd_tens, 0);
    chk("ar_valid", bcd_valid, 0);
    chk("ar_disp", display_out, 0);
    chk("ar_sel", digit_sel, 0);
    chk("ar_en", digit_en, 0);
    chk("ar_hi", hi_score, 0);
    step(2);
    reset = 1'b0;
    state = 3'd1;
    score = 7'd77;
    step(8);
    chk("ar_valid_e8", bcd_valid, 0);
    step(1);
    chk("ar_valid_e9", bcd_valid, 1);
    chk("ar_tens77", bcd_tens, 7);
    chk("ar_ones77", bcd_ones, 7);
    chk("ar_hi_after", hi_score, 0);
    $display("[TB] async reset mid-conversion, then 77 -> %0d%0d", bcd_tens, bcd_ones);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
